// File: rtl/usr_spi_regbank_pkg.sv
// Shared definitions for the SPI register bank: header field layout, address width,
// lock-key register index and the frame FSM state type.
package usr_spi_regbank_pkg;

    localparam int HDR_W         = 8;
    localparam int HDR_RW_BIT    = 7;
    localparam int ADDR_W        = 7;
    localparam int WLOCK_KEY_IDX = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } state_e;

endpackage

// File: rtl/usr_spi_sync.sv
// Two-flop synchroniser for one asynchronous SPI input, with rise/fall detection
// on the synchronised copy. All flops reset low.
module usr_spi_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    // sync_q[2] is only the previous synchronised value, used for edge detection
    assign q_o    = sync_q[1];
    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/usr_spi_regbank.sv
// SPI mode-0 slave register bank: 8-bit {rw, addr} header followed by DWIDTH-bit burst words.
// Define USR_SPI_REGBANK_WLOCK_EN to gate RW writes behind the key held in RW word 0.
module usr_spi_regbank
    import usr_spi_regbank_pkg::*;
#(
    parameter int                 DWIDTH    = 16,
    parameter int                 RO_COUNT  = 8,
    parameter int                 RW_COUNT  = 16,
    parameter logic [DWIDTH-1:0]  RW_RESET  = '0,
    parameter logic [DWIDTH-1:0]  WLOCK_KEY = DWIDTH'(16'hA5C3)
) (
    input  logic                         p_in_clk,
    input  logic                         p_in_rst_n,
    input  logic                         p_in_spi_cs_n,
    input  logic                         p_in_spi_clk,
    input  logic                         p_in_spi_mosi,
    output logic                         p_out_spi_miso,
    output logic                         p_out_spi_oe,
    input  logic [RO_COUNT*DWIDTH-1:0]   p_in_ro_data,
    output logic [RW_COUNT*DWIDTH-1:0]   p_out_rw_data,
    output logic                         p_out_wr_en,
    output logic [ADDR_W-1:0]            p_out_wr_addr,
    output logic [DWIDTH-1:0]            p_out_wr_data,
    output logic                         p_out_frame_err
);

`ifdef USR_SPI_REGBANK_WLOCK_EN
    localparam bit WLOCK_ON = 1'b1;
`else
    localparam bit WLOCK_ON = 1'b0;
`endif

    localparam int CNT_W  = $clog2(DWIDTH);
    localparam int NWORDS = RO_COUNT + RW_COUNT;

    logic cs_n_s, cs_rise, cs_fall, cs_unused_rise;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    usr_spi_sync u_sync_cs (
        .clk_i(p_in_clk), .rst_n_i(p_in_rst_n), .d_i(p_in_spi_cs_n),
        .q_o(cs_n_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    usr_spi_sync u_sync_sclk (
        .clk_i(p_in_clk), .rst_n_i(p_in_rst_n), .d_i(p_in_spi_clk),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    usr_spi_sync u_sync_mosi (
        .clk_i(p_in_clk), .rst_n_i(p_in_rst_n), .d_i(p_in_spi_mosi),
        .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    logic unused_sync;
    assign cs_unused_rise = 1'b0;
    assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall, cs_unused_rise};

    state_e              state_q;
    logic                armed_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [DWIDTH-1:0]   rx_q, tx_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                rd_q, miso_q, frame_err_q;
    logic                wr1_vld_q;
    logic [ADDR_W-1:0]   wr1_addr_q;
    logic [DWIDTH-1:0]   wr1_data_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DWIDTH-1:0]   wr_data_q;
    logic [DWIDTH-1:0]   regs_q [RW_COUNT];

    logic [DWIDTH-1:0]   rx_d;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DWIDTH-1:0]   rd_word;
    logic                hdr_done, word_done, wr_accept;

    assign rx_d      = {rx_q[DWIDTH-2:0], mosi_s};
    assign hdr_done  = sclk_rise && (bit_cnt_q == CNT_W'(HDR_W - 1));
    assign word_done = sclk_rise && (bit_cnt_q == CNT_W'(DWIDTH - 1));

    // During the header the word to preload is the one being addressed; afterwards the next one
    assign rd_addr = (state_q == ST_HDR) ? rx_d[ADDR_W-1:0] : ADDR_W'(addr_q + 1'b1);

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < RO_COUNT; k++)
            if (rd_addr == ADDR_W'(k)) rd_word = p_in_ro_data[k*DWIDTH +: DWIDTH];
        for (int k = 0; k < RW_COUNT; k++)
            if (rd_addr == ADDR_W'(RO_COUNT + k)) rd_word = regs_q[k];
    end

    assign wr_accept = wr1_vld_q
                    && (int'(wr1_addr_q) >= RO_COUNT) && (int'(wr1_addr_q) < NWORDS)
                    && (!WLOCK_ON
                        || (int'(wr1_addr_q) == RO_COUNT + WLOCK_KEY_IDX)
                        || (regs_q[WLOCK_KEY_IDX] == WLOCK_KEY));

    always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
        if (!p_in_rst_n) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
            wr1_vld_q   <= 1'b0;
            wr1_addr_q  <= '0;
            wr1_data_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int k = 0; k < RW_COUNT; k++) regs_q[k] <= RW_RESET;
        end else begin
            // Frames are only accepted once CS has been seen idle after reset
            armed_q     <= armed_q | cs_n_s;
            frame_err_q <= 1'b0;
            wr1_vld_q   <= 1'b0;
            wr_en_q     <= wr_accept;
            if (wr_accept) begin
                wr_addr_q <= wr1_addr_q;
                wr_data_q <= wr1_data_q;
                for (int k = 0; k < RW_COUNT; k++)
                    if (wr1_addr_q == ADDR_W'(RO_COUNT + k)) regs_q[k] <= wr1_data_q;
            end

            if (cs_rise && state_q != ST_IDLE) begin
                state_q     <= ST_IDLE;
                frame_err_q <= (bit_cnt_q != '0);
                bit_cnt_q   <= '0;
                miso_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (armed_q && cs_fall) begin
                            state_q   <= ST_HDR;
                            bit_cnt_q <= '0;
                            miso_q    <= 1'b0;
                            tx_q      <= '0;
                        end
                    end
                    ST_HDR: begin
                        if (sclk_rise) begin
                            rx_q <= rx_d;
                            if (hdr_done) begin
                                state_q   <= ST_DATA;
                                bit_cnt_q <= '0;
                                addr_q    <= rx_d[ADDR_W-1:0];
                                rd_q      <= rx_d[HDR_RW_BIT];
                                tx_q      <= rx_d[HDR_RW_BIT] ? rd_word : '0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sclk_fall) begin
                            miso_q <= tx_q[DWIDTH-1];
                            tx_q   <= {tx_q[DWIDTH-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            rx_q <= rx_d;
                            if (word_done) begin
                                bit_cnt_q <= '0;
                                addr_q    <= ADDR_W'(addr_q + 1'b1);
                                tx_q      <= rd_q ? rd_word : '0;
                                if (!rd_q) begin
                                    wr1_vld_q  <= 1'b1;
                                    wr1_addr_q <= addr_q;
                                    wr1_data_q <= rx_d;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < RW_COUNT; g++) begin : g_rw_out
        assign p_out_rw_data[g*DWIDTH +: DWIDTH] = regs_q[g];
    end

    assign p_out_spi_oe    = armed_q & ~cs_n_s;
    assign p_out_spi_miso  = miso_q & p_out_spi_oe;
    assign p_out_wr_en     = wr_en_q;
    assign p_out_wr_addr   = wr_addr_q;
    assign p_out_wr_data   = wr_data_q;
    assign p_out_frame_err = frame_err_q;

endmodule

// File: tb/tb_usr_spi_regbank.sv
// Bench for usr_spi_regbank: an SPI master drives directed and random frames; a word-level
// register model predicts read data, accepted writes and frame errors.
module tb_usr_spi_regbank;

    localparam int DW  = 16;
    localparam int RO  = 8;
    localparam int RWC = 16;
    localparam logic [DW-1:0] KEY = 16'hA5C3;
`ifdef USR_SPI_REGBANK_WLOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n, cs_n, sclk, mosi;
    logic              miso, oe, wr_en, ferr;
    logic [6:0]        wr_addr;
    logic [DW-1:0]     wr_data;
    logic [RO*DW-1:0]  ro_data;
    logic [RWC*DW-1:0] rw_data;

    always #5 clk = ~clk;

    usr_spi_regbank dut (
        .p_in_clk(clk), .p_in_rst_n(rst_n), .p_in_spi_cs_n(cs_n),
        .p_in_spi_clk(sclk), .p_in_spi_mosi(mosi),
        .p_out_spi_miso(miso), .p_out_spi_oe(oe),
        .p_in_ro_data(ro_data), .p_out_rw_data(rw_data),
        .p_out_wr_en(wr_en), .p_out_wr_addr(wr_addr), .p_out_wr_data(wr_data),
        .p_out_frame_err(ferr)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ro_m [RO];
    logic [DW-1:0] rw_m [RWC];
    logic [DW-1:0] tx_w [8];
    logic [DW-1:0] rx_w [8];
    logic [DW-1:0] exp_rx [8];
    logic [22:0]   wr_log[$];
    logic [22:0]   exp_log[$];
    int            ferr_cnt = 0;
    int            exp_ferr = 0;

    always @(negedge clk) begin
        if (wr_en) wr_log.push_back({wr_addr, wr_data});
        if (ferr) ferr_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] m_word(input int a);
        if (a < RO) return ro_m[a];
        if (a < RO + RWC) return rw_m[a - RO];
        return '0;
    endfunction

    task automatic load_ro();
        for (int k = 0; k < RO; k++) ro_data[k*DW +: DW] = ro_m[k];
    endtask

    task automatic model_frame(input logic [7:0] hdr, input int nw);
        int a;
        a = int'(hdr[6:0]);
        for (int i = 0; i < nw; i++) begin
            if (hdr[7]) begin
                exp_rx[i] = m_word(a);
            end else if (a >= RO && a < RO + RWC && (!LOCK || a == RO || rw_m[0] == KEY)) begin
                rw_m[a - RO] = tx_w[i];
                exp_log.push_back({7'(a), tx_w[i]});
            end
            a = (a + 1) % 128;
        end
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, output logic [31:0] r);
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            #80;
            r = {r[30:0], miso};
            sclk = 1'b1;
            #80;
            sclk = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_wr_cnt"}, 64'(wr_log.size()), 64'(exp_log.size()));
        while (wr_log.size() > 0 && exp_log.size() > 0)
            chk({tag, "_wr_entry"}, 64'(wr_log.pop_front()), 64'(exp_log.pop_front()));
        wr_log.delete();
        exp_log.delete();
        chk({tag, "_ferr_cnt"}, 64'(ferr_cnt), 64'(exp_ferr));
        for (int k = 0; k < RWC; k++)
            chk({tag, "_rw_word"}, 64'(rw_data[k*DW +: DW]), 64'(rw_m[k]));
    endtask

    task automatic do_frame(input string tag, input logic [7:0] hdr, input int nw);
        logic [31:0] r;
        cs_n = 1'b0;
        #100;
        chk({tag, "_oe_active"}, 64'(oe), 64'd1);
        send_bits(32'(hdr), 8, r);
        for (int i = 0; i < nw; i++) begin
            send_bits(32'(tx_w[i]), DW, r);
            rx_w[i] = r[DW-1:0];
        end
        #80;
        cs_n = 1'b1;
        #200;
        chk({tag, "_oe_idle"}, 64'(oe), 64'd0);
        chk({tag, "_miso_idle"}, 64'(miso), 64'd0);
        model_frame(hdr, nw);
        if (hdr[7])
            for (int i = 0; i < nw; i++) chk({tag, "_rd_word"}, 64'(rx_w[i]), 64'(exp_rx[i]));
        check_state(tag);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  hdr;
        int          nw;
        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        for (int k = 0; k < RO; k++) ro_m[k] = DW'($urandom);
        for (int k = 0; k < RWC; k++) rw_m[k] = '0;
        load_ro();
        #50;
        rst_n = 1'b1;
        #100;

        // Reset state
        chk("rst_miso", 64'(miso), 64'd0);
        chk("rst_oe", 64'(oe), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_ferr", 64'(ferr), 64'd0);
        check_state("rst");

        // Single write to the first RW word
        tx_w[0] = 16'h1234;
        do_frame("wr1", 8'h08, 1);

        // Read of RO word 0
        ro_m[0] = 16'hBEEF;
        load_ro();
        do_frame("rd_ro0", 8'h80, 1);

        // Burst write with auto-increment
        tx_w[0] = 16'd1; tx_w[1] = 16'd2; tx_w[2] = 16'd3;
        do_frame("burst_wr", 8'h09, 3);

        // CS released after 5 data bits
        cs_n = 1'b0; #100;
        send_bits(32'h09, 8, r);
        send_bits(32'h15, 5, r);
        #80; cs_n = 1'b1; #200;
        exp_ferr++;
        check_state("abort_data");

        // CS released mid-header
        cs_n = 1'b0; #100;
        send_bits(32'h5, 3, r);
        #80; cs_n = 1'b1; #200;
        exp_ferr++;
        check_state("abort_hdr");

        // Header-only frame ends cleanly on a word boundary
        do_frame("hdr_only", 8'h09, 0);

        // Lock-key sequence
        tx_w[0] = 16'h0000;
        do_frame("relock", 8'h08, 1);
        tx_w[0] = 16'h5555;
        do_frame("locked_wr", 8'h09, 1);
        tx_w[0] = KEY;
        do_frame("key_wr", 8'h08, 1);
        tx_w[0] = 16'h5555;
        do_frame("unlocked_wr", 8'h09, 1);

        // Writes to RO and unmapped addresses, read wrapping 127 -> 0
        tx_w[0] = 16'hDEAD;
        do_frame("wr_ro", 8'h03, 1);
        do_frame("wr_unmapped", 8'h40, 1);
        do_frame("rd_wrap", 8'hFF, 2);

        // Burst read across the RO/RW boundary
        do_frame("rd_span", 8'h86, 4);

        // Random frames against the model
        for (int it = 0; it < 14; it++) begin
            for (int k = 0; k < RO; k++) ro_m[k] = DW'($urandom);
            load_ro();
            nw = $urandom_range(0, 3);
            for (int i = 0; i < nw; i++) tx_w[i] = DW'($urandom);
            hdr[7] = 1'($urandom_range(0, 1));
            hdr[6:0] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(120, 127))
                                                   : 7'($urandom_range(0, 27));
            if ($urandom_range(0, 3) == 0) begin
                hdr = 8'h08;
                if (nw == 0) nw = 1;
                tx_w[0] = KEY;
            end
            do_frame("rand", hdr, nw);
        end

        // Asynchronous reset in the middle of a write frame
        cs_n = 1'b0; #100;
        send_bits(32'h0, 4, r);
        rst_n = 1'b0; #30; rst_n = 1'b1;
        for (int k = 0; k < RWC; k++) rw_m[k] = '0;
        send_bits(32'h9, 4, r);
        chk("midrst_oe", 64'(oe), 64'd0);
        send_bits(32'hCAFE, DW, r);
        #80; cs_n = 1'b1; #200;
        chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
        check_state("midrst");

        // Normal operation resumes on the next CS fall
        tx_w[0] = 16'h0BAD;
        do_frame("post_rst_wr", 8'h0A, 1);
        do_frame("post_rst_rd", 8'h8A, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
